// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer: one shift stage plus one holding register,
// valid/ready on both sides, per-word length and bit order.
module piso_stream #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH+1)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_i,
  input  logic [CW-1:0]    len_i,
  input  logic             lsb_first_i,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_o,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             last_o,
  output logic             busy_o
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [CW-1:0] WLEN = CW'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    cnt_q;
  logic             lsb_q;
  logic             hold_valid_q;
  logic [WIDTH-1:0] hold_data_q;
  logic [CW-1:0]    hold_len_q;
  logic             hold_lsb_q;

  logic acc, adv, last_hs;
  logic [CW-1:0]    len_d;
  logic [WIDTH-1:0] shift_d;

  // Zero and oversize lengths both mean a full word.
  always_comb begin
    len_d = len_i;
    if (len_i == '0 || len_i > WLEN) len_d = WLEN;
  end

  always_comb begin
    shift_d = lsb_q ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};
  end

  assign ready_out = ~hold_valid_q;
  assign valid_out = (state_q == SHIFT);
  assign acc       = valid_in & ready_out;
  assign adv       = valid_out & ready_in;
  assign last_hs   = adv & (cnt_q == CW'(1));
  assign data_o    = valid_out & (lsb_q ? shift_q[0] : shift_q[WIDTH-1]);
  assign last_o    = valid_out & (cnt_q == CW'(1));
  assign busy_o    = (state_q == SHIFT) | hold_valid_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      lsb_q        <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_len_q   <= '0;
      hold_lsb_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            state_q <= SHIFT;
            shift_q <= data_i;
            cnt_q   <= len_d;
            lsb_q   <= lsb_first_i;
          end
        end
        SHIFT: begin
          if (last_hs) begin
            // Held word takes priority; acc cannot fire while the hold is full.
            if (hold_valid_q) begin
              shift_q      <= hold_data_q;
              cnt_q        <= hold_len_q;
              lsb_q        <= hold_lsb_q;
              hold_valid_q <= 1'b0;
            end else if (acc) begin
              shift_q <= data_i;
              cnt_q   <= len_d;
              lsb_q   <= lsb_first_i;
            end else begin
              state_q <= IDLE;
              shift_q <= '0;
              cnt_q   <= '0;
            end
          end else begin
            if (adv) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_q - CW'(1);
            end
            if (acc) begin
              hold_valid_q <= 1'b1;
              hold_data_q  <= data_i;
              hold_len_q   <= len_d;
              hold_lsb_q   <= lsb_first_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream at WIDTH=8; inputs driven and outputs sampled on negedge.
module tb_piso_stream;
  localparam int WIDTH = 8;
  localparam int CW = $clog2(WIDTH+1);

  logic             clk_in = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [CW-1:0]    len_i = '0;
  logic             lsb_first_i = 1'b0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic             data_o;
  logic             valid_out;
  logic             ready_in = 1'b0;
  logic             last_o;
  logic             busy_o;

  int total = 0;
  int bad = 0;

  piso_stream #(.WIDTH(WIDTH)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_i(data_i), .len_i(len_i),
    .lsb_first_i(lsb_first_i), .valid_in(valid_in), .ready_out(ready_out),
    .data_o(data_o), .valid_out(valid_out), .ready_in(ready_in),
    .last_o(last_o), .busy_o(busy_o)
  );

  always #5 clk_in = ~clk_in;

  task automatic test_reset();
    #1;
    total++;
    if ({valid_out, ready_out, busy_o, data_o, last_o} !== 5'b01000) begin
      bad++;
      $display("FAIL reset_init got v/r/b/d/l=%b want 01000", {valid_out, ready_out, busy_o, data_o, last_o});
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    data_i = 8'hB4; len_i = 0; lsb_first_i = 0; valid_in = 1; ready_in = 0;
    @(negedge clk_in);
    data_i = 8'h81;
    @(negedge clk_in);
    valid_in = 0;
    total++;
    if ({valid_out, ready_out, busy_o, data_o} !== 4'b1011) begin
      bad++;
      $display("FAIL reset_pre got v/r/b/d=%b want 1011", {valid_out, ready_out, busy_o, data_o});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({valid_out, ready_out, busy_o, data_o, last_o} !== 5'b01000) begin
      bad++;
      $display("FAIL reset_async got v/r/b/d/l=%b want 01000", {valid_out, ready_out, busy_o, data_o, last_o});
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    ready_in = 1;
    @(negedge clk_in);
    total++;
    if (valid_out !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush got v=%b b=%b want 0 0", valid_out, busy_o);
    end
  endtask

  task automatic test_msb();
    logic [7:0] exp = 8'b10110100;
    data_i = 8'hB4; len_i = 0; lsb_first_i = 0; valid_in = 1; ready_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp[7-i] || last_o !== (i == 7)) begin
        bad++;
        $display("FAIL msb bit%0d got v=%b d=%b l=%b want 1 %b %b", i, valid_out, data_o, last_o, exp[7-i], i == 7);
      end
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0 || data_o !== 1'b0 || last_o !== 1'b0) begin
      bad++;
      $display("FAIL msb_end got v=%b d=%b l=%b want 0 0 0", valid_out, data_o, last_o);
    end
  endtask

  task automatic test_lsb_len();
    logic [7:0] exp4 = 8'b00000010;
    logic [7:0] exp8 = 8'b00101101;
    data_i = 8'hB4; len_i = 4; lsb_first_i = 1; valid_in = 1; ready_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp4[3-i] || last_o !== (i == 3)) begin
        bad++;
        $display("FAIL lsb4 bit%0d got v=%b d=%b l=%b want 1 %b %b", i, valid_out, data_o, last_o, exp4[3-i], i == 3);
      end
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL lsb4_end got v=%b want 0", valid_out);
    end
    data_i = 8'hB4; len_i = 12; lsb_first_i = 1; valid_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp8[7-i] || last_o !== (i == 7)) begin
        bad++;
        $display("FAIL clamp bit%0d got v=%b d=%b l=%b want 1 %b %b", i, valid_out, data_o, last_o, exp8[7-i], i == 7);
      end
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL clamp_end got v=%b want 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp = 16'b10100101_00111100;
    data_i = 8'hA5; len_i = 0; lsb_first_i = 0; valid_in = 1; ready_in = 1;
    @(negedge clk_in);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp[15-i] || last_o !== (i == 7 || i == 15) ||
          ready_out !== !(i >= 1 && i <= 7)) begin
        bad++;
        $display("FAIL b2b bit%0d got v=%b d=%b l=%b r=%b want 1 %b %b %b", i, valid_out, data_o, last_o,
                 ready_out, exp[15-i], (i == 7 || i == 15), !(i >= 1 && i <= 7));
      end
      if (i == 0) begin
        data_i = 8'h3C; lsb_first_i = 1;
      end
      if (i == 1) valid_in = 0;
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got v=%b b=%b want 0 0", valid_out, busy_o);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp = 8'b10110100;
    data_i = 8'hB4; len_i = 0; lsb_first_i = 0; valid_in = 1; ready_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp[7-i] || last_o !== (i == 7)) begin
        bad++;
        $display("FAIL bp bit%0d got v=%b d=%b l=%b want 1 %b %b", i, valid_out, data_o, last_o, exp[7-i], i == 7);
      end
      if (i == 2) begin
        ready_in = 0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_in);
          total++;
          if (valid_out !== 1'b1 || data_o !== 1'b1 || last_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_hold%0d got v=%b d=%b l=%b want 1 1 0", k, valid_out, data_o, last_o);
          end
        end
        ready_in = 1;
      end
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_end got v=%b want 0", valid_out);
    end
  endtask

  task automatic test_midword_reset();
    logic [7:0] exp = 8'b10000001;
    data_i = 8'hFF; len_i = 0; lsb_first_i = 0; valid_in = 1; ready_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== 1'b1) begin
        bad++;
        $display("FAIL mid_pre bit%0d got v=%b d=%b want 1 1", i, valid_out, data_o);
      end
      @(negedge clk_in);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || data_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got v=%b d=%b b=%b want 0 0 0", valid_out, data_o, busy_o);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    data_i = 8'h81; len_i = 0; lsb_first_i = 0; valid_in = 1;
    @(negedge clk_in);
    valid_in = 0;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid_out !== 1'b1 || data_o !== exp[7-i] || last_o !== (i == 7)) begin
        bad++;
        $display("FAIL mid_post bit%0d got v=%b d=%b l=%b want 1 %b %b", i, valid_out, data_o, last_o, exp[7-i], i == 7);
      end
      @(negedge clk_in);
    end
    total++;
    if (valid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_end got v=%b want 0", valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb_len();
    test_back_to_back();
    test_backpressure();
    test_midword_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (WIDTH >= 2).
REQ-002 The block SHALL derive CW = $clog2(WIDTH+1) as the width of the length field.
REQ-003 clk_in  input  1  the single clock; all state SHALL change on its rising edge, except on reset.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 data_i  input  WIDTH  parallel word to serialise.
REQ-006 len_i  input  CW  number of bits to send, taken from the low end of the word in LSB mode or the high end in MSB mode; 0 means WIDTH.
REQ-007 lsb_first_i  input  1  bit order for this word: 1 = LSB first, 0 = MSB first.
REQ-008 valid_in  input  1  upstream word valid.
REQ-009 ready_out  output  1  block can accept a word.
REQ-010 data_o  output  1  serial bit.
REQ-011 valid_out  output  1  data_o is valid.
REQ-012 ready_in  input  1  downstream accepts the current bit.
REQ-013 last_o  output  1  current bit is the final bit of its word.
REQ-014 busy_o  output  1  shifter or holding register is occupied.

Function
REQ-015 A word SHALL be accepted on a rising edge where valid_in && ready_out; data_i, len_i and lsb_first_i SHALL be captured together on that edge.
REQ-016 The block SHALL contain one shift stage and one holding register; ready_out SHALL be ~hold_valid and SHALL NOT depend combinationally on valid_in.
REQ-017 Shifter states SHALL be IDLE and SHIFT; IDLE->SHIFT on load; SHIFT->IDLE on the last-bit handshake when the holding register is empty and no word is accepted on that edge.
REQ-018 An accepted word SHALL load directly into the shifter when the shifter is IDLE, or when it is in SHIFT and completes its last-bit handshake on the same edge with the holding register empty; otherwise the word SHALL go to the holding register.
REQ-019 On a last-bit handshake with the holding register full, the held word SHALL move to the shifter on that edge, and ready_out SHALL rise in the next cycle.
REQ-020 valid_out SHALL be high in every SHIFT cycle, and first in the cycle after the word is loaded (latency of 1 clock from acceptance to the first bit).
REQ-021 A bit SHALL advance only on a clock where valid_out && ready_in; data_o, last_o and valid_out SHALL hold stable while ready_in=0 (no retraction).
REQ-022 In MSB mode data_o SHALL present bits WIDTH-1 downward; in LSB mode it SHALL present bits 0 upward.
REQ-023 A down-counter of CW bits SHALL hold the remaining bit count; len_i values > WIDTH SHALL be clamped to WIDTH, and 0 SHALL load WIDTH.
REQ-024 last_o SHALL be high only while the remaining count equals 1 and valid_out=1.
REQ-025 With valid_in and ready_in continuously high, back-to-back words SHALL produce contiguous valid_out with no bubble cycle.
REQ-026 When valid_out=0, data_o and last_o SHALL be 0.
REQ-027 busy_o SHALL be (state==SHIFT) || hold_valid.

Reset
REQ-028 rst_n=0 SHALL immediately force the following, independent of clk_in: state=IDLE, hold_valid=0, counter=0, shift register=0, valid_out=0, data_o=0, last_o=0, busy_o=0, ready_out=1.
REQ-029 A reset asserted mid-word SHALL discard both the partial word and the held word, with no further bits emitted.
REQ-030 After rst_n deasserts, a word SHALL be acceptable on the first rising edge.

Verification (WIDTH=8)
REQ-031 Reset: rst_n=0 asynchronously between edges -> valid_out=0, ready_out=1, busy_o=0, data_o=0 at once.
REQ-032 MSB mode: data_i=8'hB4, len_i=0, ready_in=1 -> bits 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting 1 cycle after acceptance, with last_o high only on the 8th.
REQ-033 LSB mode: data_i=8'hB4, len_i=4 -> bits 0,0,1,0, with last_o on the 4th; also len_i=12 -> 8 bits sent (clamped).
REQ-034 Back-to-back: 8'hA5 MSB then 8'h3C LSB with ready_in=1 -> 16 contiguous bits 10100101 00111100, ready_out=0 from the second acceptance until the edge after the first word's last bit.
REQ-035 Backpressure: ready_in=0 for 3 cycles after bit 2 of 8'hB4 -> data_o=1 and valid_out=1 held; the remaining bits are then emitted in order with none lost or duplicated.
REQ-036 Mid-word reset: rst_n pulsed low after 3 bits of 8'hFF -> valid_out drops immediately; a following word 8'h81 is serialised correctly as 1,0,0,0,0,0,0,1.
